tr_arbiter: RTL and testbench

TR_ARBITER -- requirements
Module: tr_arbiter

---
 rtl/tr_arbiter.sv | 137 +++++++++++++
 tb/tb_tr_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/tr_arbiter.sv
// Transaction arbiter: grants one of NUM request channels, holds the grant through ack/done.
// Policy: fixed priority (channel 0 highest) by default; define TR_ARB_RR_EN for round-robin.
module tr_arbiter #(
  parameter int NUM  = 16,
  parameter int SELW = 4
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic [NUM-1:0]  i_req,
  input  logic            i_ack,
  input  logic            i_done,
  output logic            o_valid,
  output logic [SELW-1:0] o_sel,
  output logic [NUM-1:0]  o_gnt,
  output logic            o_busy,
  output logic [1:0]      o_state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GRANT = 2'b01,
    ST_HOLD  = 2'b10
  } state_e;

  // Channel 0 lives on the MSB of i_req/o_gnt.
  localparam logic [NUM-1:0] CH0_BIT = {1'b1, {(NUM-1){1'b0}}};

  state_e          state_q, state_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [NUM-1:0]  gnt_q, gnt_d;
  logic [NUM-1:0]  ch;
  logic            found;
  logic [SELW-1:0] win;

  // ch[k] is the request of channel k.
  assign ch    = {<<{i_req}};
  assign found = |ch;

`ifdef TR_ARB_RR_EN
  logic [SELW-1:0] ptr_q, ptr_d;
  logic [NUM-1:0]  rot;
  logic [SELW-1:0] off;
  logic            complete;

  function automatic logic [SELW-1:0] wrap_add(input logic [SELW-1:0] a,
                                               input logic [SELW-1:0] b);
    logic [SELW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= (SELW+1)'(NUM)) s = s - (SELW+1)'(NUM);
    return s[SELW-1:0];
  endfunction

  // Rotate so the pointer channel sits at bit 0, then take the lowest set bit.
  always_comb begin
    rot = NUM'({ch, ch} >> ptr_q);
    off = '0;
    for (int i = NUM - 1; i >= 0; i--) begin
      if (rot[i]) off = SELW'(i);
    end
    win = wrap_add(ptr_q, off);
  end

  assign complete = ((state_q == ST_GRANT) && i_ack && i_done) ||
                    ((state_q == ST_HOLD) && i_done);
  assign ptr_d    = complete ? wrap_add(sel_q, SELW'(1)) : ptr_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end
`else
  always_comb begin
    win = '0;
    for (int i = NUM - 1; i >= 0; i--) begin
      if (ch[i]) win = SELW'(i);
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d = ST_GRANT;
          sel_d   = win;
          gnt_d   = CH0_BIT >> win;
        end else begin
          sel_d = '0;
          gnt_d = '0;
        end
      end
      ST_GRANT: begin
        if (i_ack && i_done) begin
          state_d = ST_IDLE;
          sel_d   = '0;
          gnt_d   = '0;
        end else if (i_ack) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (i_done) begin
          state_d = ST_IDLE;
          sel_d   = '0;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = '0;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
    end
  end

  assign o_valid     = (state_q == ST_GRANT);
  assign o_busy      = (state_q == ST_GRANT) || (state_q == ST_HOLD);
  assign o_sel       = sel_q;
  assign o_gnt       = gnt_q;
  assign o_state_dbg = state_q;

endmodule

// File: tb/tb_tr_arbiter.sv
// Bench for tr_arbiter: directed vector table, reset/round-robin sequences, random traffic vs model.
module tb_tr_arbiter;
  localparam int NUM  = 16;
  localparam int SELW = 4;

  logic            i_clk;
  logic            i_rstn;
  logic [NUM-1:0]  i_req;
  logic            i_ack;
  logic            i_done;
  logic            o_valid;
  logic [SELW-1:0] o_sel;
  logic [NUM-1:0]  o_gnt;
  logic            o_busy;
  logic [1:0]      o_state_dbg;

  tr_arbiter #(.NUM(NUM), .SELW(SELW)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_req(i_req), .i_ack(i_ack), .i_done(i_done),
    .o_valid(o_valid), .o_sel(o_sel), .o_gnt(o_gnt), .o_busy(o_busy),
    .o_state_dbg(o_state_dbg)
  );

  // ---------------- clock ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // phase: 0 = no grant, 1 = grant offered, 2 = grant accepted and held
  int m_phase = 0;
  int m_sel   = 0;
  int m_ptr   = 0;

  task automatic model_reset();
    m_phase = 0;
    m_sel   = 0;
    m_ptr   = 0;
  endtask

  task automatic model_step(input logic [NUM-1:0] req, input logic ack, input logic done);
    int cands[$];
    int best;
    bit finish;
    finish = 1'b0;
    if (m_phase == 0) begin
      for (int k = 0; k < NUM; k++) if (req[NUM-1-k]) cands.push_back(k);
      if (cands.size() > 0) begin
        best = cands[0];
`ifdef TR_ARB_RR_EN
        foreach (cands[j])
          if ((cands[j] - m_ptr + NUM) % NUM < (best - m_ptr + NUM) % NUM) best = cands[j];
`endif
        m_sel   = best;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (ack && done) finish = 1'b1;
      else if (ack) m_phase = 2;
    end else begin
      if (done) finish = 1'b1;
    end
    if (finish) begin
      m_ptr   = (m_sel + 1) % NUM;
      m_sel   = 0;
      m_phase = 0;
    end
  endtask

  function automatic logic [NUM-1:0] model_gnt();
    logic [NUM-1:0] g;
    g = '0;
    if (m_phase != 0) g[NUM-1-m_sel] = 1'b1;
    return g;
  endfunction

  task automatic check_model();
    chk("valid", 64'(o_valid), 64'(m_phase == 1));
    chk("busy",  64'(o_busy),  64'(m_phase != 0));
    chk("sel",   64'(o_sel),   64'(m_sel));
    chk("gnt",   64'(o_gnt),   64'(model_gnt()));
    chk("gnt_onehot", 64'($countones(o_gnt) <= 1), 64'(1));
    chk("gnt_vs_sel", 64'((o_gnt == '0) || (o_gnt == (16'h8000 >> o_sel))), 64'(1));
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic [NUM-1:0] req, input logic ack, input logic done);
    @(negedge i_clk);
    i_req  = req;
    i_ack  = ack;
    i_done = done;
    @(posedge i_clk);
    model_step(req, ack, done);
    #1;
    check_model();
  endtask

  // Asserts reset mid-cycle, checks the immediate effect, then releases on a falling edge.
  task automatic do_reset(input string nm);
    #2;
    i_rstn = 1'b0;
    i_req  = '0;
    i_ack  = 1'b0;
    i_done = 1'b0;
    #1;
    chk({nm, "_valid"}, 64'(o_valid), 64'(0));
    chk({nm, "_sel"},   64'(o_sel),   64'(0));
    chk({nm, "_gnt"},   64'(o_gnt),   64'(0));
    chk({nm, "_busy"},  64'(o_busy),  64'(0));
    model_reset();
    @(negedge i_clk);
    @(negedge i_clk);
    i_rstn = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [NUM-1:0] req;
    logic           ack;
    logic           done;
    logic           valid;
    int             sel;
    logic [NUM-1:0] gnt;
    logic           busy;
  } vec_t;

  vec_t vecs[18];

  initial begin
    vecs[0]  = '{16'h8001, 1'b0, 1'b0, 1'b1, 0,  16'h8000, 1'b1};
    vecs[1]  = '{16'h0000, 1'b1, 1'b1, 1'b0, 0,  16'h0000, 1'b0};
    vecs[2]  = '{16'h0010, 1'b0, 1'b0, 1'b1, 11, 16'h0010, 1'b1};
    vecs[3]  = '{16'h0010, 1'b1, 1'b0, 1'b0, 11, 16'h0010, 1'b1};
    vecs[4]  = '{16'h0010, 1'b0, 1'b0, 1'b0, 11, 16'h0010, 1'b1};
    vecs[5]  = '{16'h0010, 1'b1, 1'b0, 1'b0, 11, 16'h0010, 1'b1};
    vecs[6]  = '{16'h0010, 1'b0, 1'b0, 1'b0, 11, 16'h0010, 1'b1};
    vecs[7]  = '{16'h0010, 1'b0, 1'b1, 1'b0, 0,  16'h0000, 1'b0};
    vecs[8]  = '{16'h0010, 1'b0, 1'b0, 1'b1, 11, 16'h0010, 1'b1};
    vecs[9]  = '{16'h0000, 1'b0, 1'b1, 1'b1, 11, 16'h0010, 1'b1};
    vecs[10] = '{16'h0000, 1'b1, 1'b1, 1'b0, 0,  16'h0000, 1'b0};
    vecs[11] = '{16'h0400, 1'b0, 1'b0, 1'b1, 5,  16'h0400, 1'b1};
    vecs[12] = '{16'h0000, 1'b0, 1'b0, 1'b1, 5,  16'h0400, 1'b1};
    vecs[13] = '{16'h0000, 1'b1, 1'b0, 1'b0, 5,  16'h0400, 1'b1};
    vecs[14] = '{16'h0000, 1'b0, 1'b1, 1'b0, 0,  16'h0000, 1'b0};
    vecs[15] = '{16'h0000, 1'b0, 1'b1, 1'b0, 0,  16'h0000, 1'b0};
    vecs[16] = '{16'h00F0, 1'b0, 1'b0, 1'b1, 8,  16'h0080, 1'b1};
    vecs[17] = '{16'h00F0, 1'b1, 1'b1, 1'b0, 0,  16'h0000, 1'b0};
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [NUM-1:0] r;
    int sel_exp;

    i_rstn = 1'b0;
    i_req  = '0;
    i_ack  = 1'b0;
    i_done = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_valid", 64'(o_valid), 64'(0));
    chk("rst_sel",   64'(o_sel),   64'(0));
    chk("rst_gnt",   64'(o_gnt),   64'(0));
    chk("rst_busy",  64'(o_busy),  64'(0));
    @(negedge i_clk);
    i_rstn = 1'b1;

    foreach (vecs[i]) begin
      cycle(vecs[i].req, vecs[i].ack, vecs[i].done);
      chk($sformatf("vec%0d_valid", i), 64'(o_valid), 64'(vecs[i].valid));
      chk($sformatf("vec%0d_sel", i),   64'(o_sel),   64'(vecs[i].sel));
      chk($sformatf("vec%0d_gnt", i),   64'(o_gnt),   64'(vecs[i].gnt));
      chk($sformatf("vec%0d_busy", i),  64'(o_busy),  64'(vecs[i].busy));
    end

    // Reset while holding channel 7 aborts the grant; pointer restarts at 0.
    do_reset("rst_a");
    cycle(16'h0100, 1'b0, 1'b0);
    chk("ch7_grant_sel", 64'(o_sel), 64'(7));
    cycle(16'h0100, 1'b1, 1'b0);
    chk("ch7_hold_busy", 64'(o_busy), 64'(1));
    do_reset("rst_hold");
    cycle(16'hFFFF, 1'b0, 1'b0);
    chk("post_rst_ptr0", 64'(o_sel), 64'(0));
    cycle(16'h0000, 1'b1, 1'b1);
    cycle(16'h0100, 1'b0, 1'b0);
    chk("post_rst_ch7", 64'(o_sel), 64'(7));
    cycle(16'h0000, 1'b1, 1'b1);

    // All channels requesting, each grant completed with ack and done together.
    do_reset("rst_b");
    for (int g = 0; g <= NUM; g++) begin
`ifdef TR_ARB_RR_EN
      sel_exp = g % NUM;
`else
      sel_exp = 0;
`endif
      cycle(16'hFFFF, 1'b0, 1'b0);
      chk($sformatf("all_req_sel%0d", g), 64'(o_sel), 64'(sel_exp));
      cycle(16'hFFFF, 1'b1, 1'b1);
      chk($sformatf("all_req_idle%0d", g), 64'(o_busy), 64'(0));
    end

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      case ($urandom_range(0, 3))
        0:       r = '0;
        1:       r = 16'h8000 >> $urandom_range(0, NUM - 1);
        2:       r = 16'($urandom);
        default: r = 16'hFFFF;
      endcase
      cycle(r, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
